// File: rtl/latch_reader_pkg.sv
// latch_reader_pkg: shared types and constants for the latch reader.
// Holds the reader FSM state encoding, the settle counter width and the
// legal ranges of the top-level parameters.
package latch_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPEN    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  localparam int CNT_W = 4;

  localparam int WIDTH_MIN         = 1;
  localparam int WIDTH_MAX         = 32;
  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int STABLE_CYCLES_MIN = 1;
  localparam int STABLE_CYCLES_MAX = 15;

endpackage

// File: rtl/latch_reader_sync.sv
// latch_sync: WIDTH-bit wide, STAGES-deep flop chain that brings an
// asynchronous signal into the clk domain. Every stage resets to 0.
module latch_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_d [STAGES];
  logic [WIDTH-1:0] chain_q [STAGES];

  // Each stage takes the value of the stage before it; stage 0 takes the pin.
  always_comb begin
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // Register the whole chain; reset drops every stage to 0 at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/latch_reader.sv
// latch_reader: clocked reader for an asynchronously written data latch.
// Synchronises latch_en/latch_q, waits for the latch to close and its data
// to hold still for STABLE_CYCLES samples, presents the word on a
// valid/ready handshake and pulses latch_clr once the word is taken.
// Optional feature macro: LATCH_READER_OVERRUN_EN adds a sticky overrun
// flag raised when the latch reopens while a word is still being presented.
module latch_reader
  import latch_reader_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             latch_en,
  input  logic [WIDTH-1:0] latch_q,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             latch_clr
`ifdef LATCH_READER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             en_s;
  logic [WIDTH-1:0] q_s;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] data_prev_d, data_prev_q;
  logic [WIDTH-1:0] rd_data_d, rd_data_q;
  logic             rd_valid_d, rd_valid_q;
  logic             latch_clr_d, latch_clr_q;
`ifdef LATCH_READER_OVERRUN_EN
  logic             overrun_d, overrun_q;
`endif

  latch_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync_en (
    .clk   (clk),
    .reset (reset),
    .d     (latch_en),
    .q     (en_s)
  );

  latch_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync_q (
    .clk   (clk),
    .reset (reset),
    .d     (latch_q),
    .q     (q_s)
  );

  // Next-state logic: track the latch open/close cycle, count equal samples
  // while settling, and run the present/clear handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_prev_d = q_s;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    latch_clr_d = latch_clr_q;
`ifdef LATCH_READER_OVERRUN_EN
    overrun_d   = overrun_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_d = ST_OPEN;
        end
      end

      ST_OPEN: begin
        if (!en_s) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end

      ST_SETTLE: begin
        if (en_s) begin
          state_d = ST_OPEN;
        end else if (q_s == data_prev_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d    = ST_PRESENT;
            rd_data_d  = q_s;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      ST_PRESENT: begin
`ifdef LATCH_READER_OVERRUN_EN
        if (en_s) begin
          overrun_d = 1'b1;
        end
`endif
        if (rd_valid_q && rd_ready) begin
          rd_valid_d  = 1'b0;
          latch_clr_d = 1'b1;
          state_d     = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        latch_clr_d = 1'b0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        rd_valid_d  = 1'b0;
        latch_clr_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_prev_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      latch_clr_q <= 1'b0;
`ifdef LATCH_READER_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_prev_q <= data_prev_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      latch_clr_q <= latch_clr_d;
`ifdef LATCH_READER_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign latch_clr = latch_clr_q;
`ifdef LATCH_READER_OVERRUN_EN
  assign overrun   = overrun_q;
`endif

endmodule
